// File: rtl/limn2600_interval_timer.sv
// Limn2600 bus-mapped interval timer: prescaled down-counter with reload and W1C pending.
// Optional 64-bit UPTIME counter at 0x10/0x14 when LIMN2600_TIMER_UPTIME_EN is defined.
module limn2600_interval_timer #(
  parameter logic [31:0] BASE     = 32'hF800_0000,
  parameter int unsigned PRESCALE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        rdy,
  output logic        irq
);

  localparam logic [2:0]  A_CTRL   = 3'd0;
  localparam logic [2:0]  A_RELOAD = 3'd1;
  localparam logic [2:0]  A_COUNT  = 3'd2;
  localparam logic [2:0]  A_STATUS = 3'd3;
`ifdef LIMN2600_TIMER_UPTIME_EN
  localparam logic [2:0]  A_UPLO   = 3'd4;
  localparam logic [2:0]  A_UPHI   = 3'd5;
`endif
  localparam logic [15:0] PS_MAX   = 16'(PRESCALE - 1);

  logic [2:0]  r_ctrl;
  logic [31:0] r_reload;
  logic [31:0] r_count;
  logic        r_pend;
  logic [15:0] r_presc;
  logic        r_rdy;
  logic [31:0] r_dout;
  logic        r_irq;

  logic        w_hit;
  logic        w_wr;
  logic        w_rd;
  logic [2:0]  w_sel;
  logic        w_wr_ctrl;
  logic        w_wr_reload;
  logic        w_wr_status;
  logic        w_tick;
  logic        w_tick_ok;
  logic        w_expire;
  logic [2:0]  w_ctrl_nxt;
  logic [31:0] w_count_nxt;
  logic [15:0] w_presc_nxt;
  logic        w_pend_nxt;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_unused = &{1'b0, addr[1:0]};

  assign w_hit = cs & (addr[31:5] == BASE[31:5]) & ~r_rdy;
  assign w_wr  = w_hit & we;
  assign w_rd  = w_hit & ~we;
  assign w_sel = addr[4:2];

  assign w_wr_ctrl   = w_wr & (w_sel == A_CTRL);
  assign w_wr_reload = w_wr & (w_sel == A_RELOAD);
  assign w_wr_status = w_wr & (w_sel == A_STATUS);

  // A RELOAD write or an EN-clearing CTRL write swallows a coincident tick
  assign w_tick    = r_ctrl[0] & (r_presc == PS_MAX);
  assign w_tick_ok = w_tick & ~w_wr_reload
                   & ~(w_wr_ctrl & ~data_in[0]);
  assign w_expire  = w_tick_ok & (r_count == 32'd0);

  always_comb begin
    w_ctrl_nxt = r_ctrl;
    if (w_wr_ctrl)
      w_ctrl_nxt = data_in[2:0];
    if (w_expire & ~w_ctrl_nxt[1])
      w_ctrl_nxt[0] = 1'b0;
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_reload)
      w_count_nxt = data_in;
    else if (w_tick_ok) begin
      if (r_count != 32'd0)
        w_count_nxt = r_count - 32'd1;
      else if (w_ctrl_nxt[1])
        w_count_nxt = r_reload;
      else
        w_count_nxt = 32'd0;
    end
  end

  always_comb begin
    w_presc_nxt = 16'd0;
    if (!(w_wr_reload | ~w_ctrl_nxt[0] | w_tick) && r_ctrl[0])
      w_presc_nxt = r_presc + 16'd1;
  end

  // Expiry beats a same-edge W1C
  assign w_pend_nxt = (r_pend & ~(w_wr_status & data_in[0])) | w_expire;

`ifdef LIMN2600_TIMER_UPTIME_EN
  logic [63:0] r_uptime;
  logic [31:0] r_up_hi;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_uptime <= 64'd0;
      r_up_hi  <= 32'd0;
    end else begin
      r_uptime <= r_uptime + 64'd1;
      if (w_rd && (w_sel == A_UPLO))
        r_up_hi <= r_uptime[63:32];
    end
  end
`endif

  always_comb begin
    w_rdata = 32'd0;
    unique case (w_sel)
      A_CTRL:   w_rdata = {29'd0, r_ctrl};
      A_RELOAD: w_rdata = r_reload;
      A_COUNT:  w_rdata = r_count;
      A_STATUS: w_rdata = {31'd0, r_pend};
`ifdef LIMN2600_TIMER_UPTIME_EN
      A_UPLO:   w_rdata = r_uptime[31:0];
      A_UPHI:   w_rdata = r_up_hi;
`endif
      default:  w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl   <= 3'd0;
      r_reload <= 32'd0;
      r_count  <= 32'd0;
      r_pend   <= 1'b0;
      r_presc  <= 16'd0;
      r_rdy    <= 1'b0;
      r_dout   <= 32'd0;
      r_irq    <= 1'b0;
    end else begin
      r_ctrl  <= w_ctrl_nxt;
      r_count <= w_count_nxt;
      r_presc <= w_presc_nxt;
      r_pend  <= w_pend_nxt;
      r_rdy   <= w_hit;
      r_dout  <= w_rd ? w_rdata : 32'd0;
      r_irq   <= r_pend & r_ctrl[2];
      if (w_wr_reload)
        r_reload <= data_in;
    end
  end

  assign data_out = r_dout;
  assign rdy      = r_rdy;
  assign irq      = r_irq;

endmodule

// File: tb/tb_limn2600_interval_timer.sv
// Directed bench for limn2600_interval_timer: two instances (PRESCALE 16 and 1)
// on one shared bus, each at its own window, checked at exact cycle numbers.
module tb_limn2600_interval_timer;

  localparam logic [31:0] B0 = 32'hF800_0000;
  localparam logic [31:0] B1 = 32'hF800_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] data_in = 32'd0;
  logic [31:0] dout0, dout1;
  logic        rdy0, rdy1, irq0, irq1;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  limn2600_interval_timer #(.BASE(B0), .PRESCALE(16)) u_dut0 (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr),
    .data_in(data_in), .data_out(dout0), .rdy(rdy0), .irq(irq0)
  );

  limn2600_interval_timer #(.BASE(B1), .PRESCALE(1)) u_dut1 (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr),
    .data_in(data_in), .data_out(dout1), .rdy(rdy1), .irq(irq1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Returns at the falling edge after posedge number e
  task automatic wait_cyc(input int e);
    if (cyc > e) check("sched", cyc, e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic bus(input bit sel, input bit w, input logic [31:0] a,
                     input logic [31:0] d,
                     output logic r1, output logic [31:0] q1, output logic i1,
                     output logic r2, output logic [31:0] q2);
    cs = 1'b1; we = w; addr = a; data_in = d;
    @(negedge clk);
    r1 = sel ? rdy1 : rdy0;
    q1 = sel ? dout1 : dout0;
    i1 = sel ? irq1 : irq0;
    cs = 1'b0; we = 1'b0;
    @(negedge clk);
    r2 = sel ? rdy1 : rdy0;
    q2 = sel ? dout1 : dout0;
  endtask

  function automatic logic [31:0] base_of(input bit sel);
    return sel ? B1 : B0;
  endfunction

  task automatic rd_at(input int e, input bit sel, input logic [4:0] off,
                       input string tag, input logic [31:0] exp);
    logic r1, i1, r2;
    logic [31:0] q1, q2;
    wait_cyc(e - 1);
    bus(sel, 1'b0, base_of(sel) + {27'd0, off}, 32'd0, r1, q1, i1, r2, q2);
    check({tag, ".rdy"}, r1, 1);
    check({tag, ".data"}, q1, exp);
    check({tag, ".rdy_end"}, r2, 0);
    check({tag, ".data_end"}, q2, 0);
  endtask

  task automatic wr_at(input int e, input bit sel, input logic [4:0] off,
                       input logic [31:0] d, input string tag);
    logic r1, i1, r2;
    logic [31:0] q1, q2;
    wait_cyc(e - 1);
    bus(sel, 1'b1, base_of(sel) + {27'd0, off}, d, r1, q1, i1, r2, q2);
    check({tag, ".rdy"}, r1, 1);
    check({tag, ".data"}, q1, 0);
    check({tag, ".rdy_end"}, r2, 0);
  endtask

  initial begin
    logic r1, i1, r2;
    logic [31:0] q1, q2;

    wait_cyc(3);
    rst = 1'b0;
    check("rst.irq", irq0, 0);
    check("rst.rdy", rdy0, 0);
    check("rst.dout", dout0, 0);
    rd_at(4, 0, 5'h00, "rst.ctrl", 0);
    rd_at(6, 0, 5'h04, "rst.reload", 0);
    rd_at(8, 0, 5'h08, "rst.count", 0);
    rd_at(10, 0, 5'h0C, "rst.status", 0);

    // Periodic: RELOAD=3, expiry every 64 cycles
    wr_at(20, 0, 5'h04, 32'd3, "per.reload");
    wr_at(22, 0, 5'h00, 32'd7, "per.ctrl");
    rd_at(32, 0, 5'h08, "per.cnt3", 3);
    rd_at(48, 0, 5'h08, "per.cnt2", 2);
    rd_at(64, 0, 5'h08, "per.cnt1", 1);
    rd_at(80, 0, 5'h08, "per.cnt0", 0);
    wait_cyc(86);  check("per.irq_pre", irq0, 0);
    wait_cyc(87);  check("per.irq_rise", irq0, 1);
    wr_at(100, 0, 5'h0C, 32'd1, "per.w1c");
    wait_cyc(101); check("per.irq_clr", irq0, 0);
    wait_cyc(150); check("per.irq2_pre", irq0, 0);
    wait_cyc(151); check("per.irq2_rise", irq0, 1);
    rd_at(160, 0, 5'h0C, "per.status", 1);
    rd_at(162, 0, 5'h00, "per.ctrlrd", 7);

    // One-shot: RELOAD=2, single expiry 48 cycles after enable
    wr_at(170, 0, 5'h00, 32'd0, "os.dis");
    wr_at(172, 0, 5'h0C, 32'd1, "os.w1c");
    wr_at(174, 0, 5'h04, 32'd2, "os.reload");
    wr_at(176, 0, 5'h00, 32'd5, "os.ctrl");
    wait_cyc(224); check("os.irq_pre", irq0, 0);
    wait_cyc(225); check("os.irq_rise", irq0, 1);
    rd_at(230, 0, 5'h00, "os.ctrl_en0", 4);
    rd_at(232, 0, 5'h08, "os.cnt0", 0);
    rd_at(300, 0, 5'h08, "os.cnt_stay", 0);
    wait_cyc(301); check("os.irq_hold", irq0, 1);
    wait_cyc(303);
    bus(0, 1'b1, B0 + 32'h0C, 32'd1, r1, q1, i1, r2, q2);
    check("os.w1c.rdy", r1, 1);
    check("os.w1c.irq_at_rdy", i1, 1);
    check("os.w1c.irq_after", irq0, 0);

    // RO/reserved offsets and window decode
    wr_at(310, 0, 5'h04, 32'd5, "ro.reload");
    wr_at(312, 0, 5'h08, 32'h1234, "ro.wr_count");
    rd_at(314, 0, 5'h08, "ro.count", 5);
    rd_at(316, 0, 5'h1C, "ro.rsvd", 0);
    wait_cyc(317);
    bus(0, 1'b0, B0 + 32'h20, 32'd0, r1, q1, i1, r2, q2);
    check("win.rd_rdy", r1, 0);
    wait_cyc(319);
    bus(0, 1'b1, B0 + 32'h24, 32'd9, r1, q1, i1, r2, q2);
    check("win.wr_rdy", r1, 0);
    rd_at(322, 0, 5'h04, "win.reload", 5);
    wr_at(324, 0, 5'h00, 32'hFFFF_FFF8, "ctrl.hi");
    rd_at(326, 0, 5'h00, "ctrl.hi_rd", 0);

    // PRESCALE=1 instance: same-edge corner cases
    wr_at(330, 1, 5'h04, 32'd0, "p1.reload0");
    wr_at(332, 1, 5'h00, 32'd7, "p1.ctrl");
    wr_at(336, 1, 5'h0C, 32'd1, "p1.w1c");
    wait_cyc(337); check("p1.irq_set_wins", irq1, 1);
    rd_at(338, 1, 5'h0C, "p1.pend", 1);
    wr_at(340, 1, 5'h04, 32'd5, "p1.reload5");
    rd_at(342, 1, 5'h08, "p1.cnt_after_load", 4);
    wr_at(344, 1, 5'h00, 32'd0, "p1.ctrl_off");
    rd_at(346, 1, 5'h08, "p1.cnt_frozen", 2);

    // Reset while running with a read in flight
    wr_at(350, 0, 5'h04, 32'd3, "mr.reload");
    wr_at(352, 0, 5'h00, 32'd7, "mr.ctrl");
    wait_cyc(417); check("mr.irq_up", irq0, 1);
    wait_cyc(420);
    cs = 1'b1; we = 1'b0; addr = B0 + 32'h08; rst = 1'b1;
    @(negedge clk);
    check("mr.rdy", rdy0, 0);
    check("mr.dout", dout0, 0);
    check("mr.irq", irq0, 0);
    cs = 1'b0; rst = 1'b0;
    rd_at(423, 0, 5'h00, "mr.ctrl0", 0);
    rd_at(425, 0, 5'h04, "mr.reload0", 0);
    rd_at(427, 0, 5'h08, "mr.count0", 0);
    rd_at(429, 0, 5'h0C, "mr.status0", 0);
    check("mr.irq_late", irq0, 0);

`ifdef LIMN2600_TIMER_UPTIME_EN
    rd_at(431, 0, 5'h10, "up.lo", 32'd9);
`else
    rd_at(431, 0, 5'h10, "up.lo", 32'd0);
`endif
    rd_at(433, 0, 5'h14, "up.hi", 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/limn2600_interval_timer.md
Name: limn2600_interval_timer

Overview:
- Memory-mapped programmable interval timer on the Limn2600 CPU bus, alongside the SRAM slave.
- Decodes its own address window from the shared cs/we/addr/data_out bus and answers with rdy.
- Drives the CPU's irq input and is the system's only interrupt source.
- Down-counter with reload, periodic/one-shot modes and a write-1-to-clear pending flag.

Parameters:
- BASE, 32'hF800_0000, window base address; must be 32-byte aligned; matched against addr[31:5].
- PRESCALE, 16, clk cycles per timer tick; legal range 1..65535.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- cs  input  1  bus request from CPU.
- we  input  1  1 = write, 0 = read; sampled with cs.
- addr  input  32  byte address; addr[4:2] selects the register, addr[1:0] ignored.
- data_in  input  32  write data from CPU.
- data_out  output  32  read data; valid only while rdy=1, otherwise 32'h0.
- rdy  output  1  one-cycle completion pulse for an accepted request.
- irq  output  1  interrupt request to CPU, level, registered.

Behaviour:
- Reset (rst=1 at an edge): CTRL=0, RELOAD=0, COUNT=0, PENDING=0, prescaler=0, rdy=0, data_out=0, irq=0. Reset overrides everything, including mid-transaction; an in-flight rdy is dropped.
- Accept: at an edge where cs=1, addr[31:5]==BASE[31:5] and rdy=0.
  - Writes commit on that edge.
  - Reads capture register contents as of that edge.
  - rdy=1 and data_out valid on the following cycle only. Latency is 1 cycle; the maximum rate is one access every 2 cycles.
  - An address mismatch never asserts rdy or changes any state.
- Register map (offset):
  - 0x00 CTRL, R/W: bit0 EN, bit1 AUTO, bit2 IE; other bits read 0.
  - 0x04 RELOAD, R/W: a write also loads COUNT and resets the prescaler.
  - 0x08 COUNT, RO.
  - 0x0C STATUS: bit0 PENDING; writing 1 to bit0 clears it.
  - 0x10/0x14: see Optional Feature.
  - 0x18/0x1C: reserved, read 0.
  - Writes to RO or reserved offsets are ignored but still get rdy.
- Prescaler:
  - While EN=1, the prescaler counts 0..PRESCALE-1; a tick occurs on the cycle it equals PRESCALE-1, then it wraps to 0.
  - While EN=0 the prescaler is held at 0.
- Tick behaviour:
  - COUNT!=0: COUNT decrements.
  - COUNT==0: PENDING is set. If AUTO=1, COUNT is set to RELOAD. If AUTO=0, EN is cleared and COUNT stays 0.
  - Period = (RELOAD+1)*PRESCALE cycles. RELOAD=0 with AUTO=1 expires on every tick.
- irq = PENDING & IE, registered. It rises 1 cycle after PENDING sets or IE is written to 1.
- Simultaneous events:
  - Expiry and STATUS W1C on the same edge: PENDING ends at 1 (set wins).
  - RELOAD write and tick on the same edge: the written value is loaded, the tick is discarded and no expiry occurs.
  - CTRL write clearing EN on a tick edge: the write wins and there is no decrement or expiry.

Optional Feature:
- Macro: LIMN2600_TIMER_UPTIME_EN.
- Defined:
  - Adds a 64-bit free-running UPTIME counter, incrementing every clk from reset value 0 and wrapping 2^64-1 to 0.
  - Reading 0x10 returns UPTIME[31:0] and, on the same edge, latches UPTIME[63:32] into a shadow register.
  - Reading 0x14 returns the shadow (reset 0).
  - Writes to both offsets are ignored.
- Undefined: 0x10/0x14 behave as reserved (read 0, rdy given) and no counter logic is synthesised.

Test Plan:
- Reset, then read 0x00/0x04/0x08/0x0C at BASE -> each returns 32'h0 with rdy exactly 1 cycle after cs accept; irq=0.
- PRESCALE=16: write RELOAD=3, then CTRL=3'b111 -> PENDING sets and irq rises; expiries repeat every 64 cycles; COUNT reads cycle 3,2,1,0.
- One-shot: RELOAD=2, CTRL=3'b101 -> single expiry after 48 cycles; CTRL then reads 3'b100; COUNT stays 0; irq stays 1 until STATUS write 1, which drops irq 1 cycle after rdy.
- Same-edge W1C and expiry with PRESCALE=1, RELOAD=0, AUTO=1 -> PENDING remains 1; read of 0x1C and write to 0x08 -> rdy given, data 0, COUNT unchanged; access at BASE+0x20 -> no rdy.
- Assert rst for 1 cycle while timer running and a read is in flight -> rdy not asserted, all registers 0, irq 0 next cycle.
- With LIMN2600_TIMER_UPTIME_EN defined: read 0x10 then 0x14 -> consistent 64-bit value, LO equals cycles since reset at the accept edge. With the macro undefined: both read 0.
